// File: rtl/fc_pkg.sv
// fc_pkg: shared defaults, FSM state type and weight-vector type for the FC PE feeder
package fc_pkg;
    localparam int FC_SIZE_DEFAULT = 8;
    localparam int DATA_W_DEFAULT = 8;
    typedef enum logic [2:0] {IDLE, LOAD_W, COMMIT, STREAM, DRAIN, DONE} fc_feeder_state_t;
    typedef logic [FC_SIZE_DEFAULT-1:0][DATA_W_DEFAULT-1:0] fc_weight_vec_t;
endpackage

// File: rtl/fc_weight_shadow.sv
// fc_weight_shadow: shadow weight bank with indexed write enable and full-bank output
module fc_weight_shadow
    import fc_pkg::*;
#(
    parameter int FC_SIZE = FC_SIZE_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IDX_W = (FC_SIZE > 1) ? $clog2(FC_SIZE) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            we,
    input  logic [IDX_W-1:0]                idx,
    input  logic [DATA_W-1:0]               wdata,
    output logic [FC_SIZE-1:0][DATA_W-1:0]  bank
);
    always_ff @(posedge clk)
        if (rst) bank <= '0;
        else if (we) bank[idx] <= wdata;
endmodule

// File: rtl/fc_pe_feeder.sv
// fc_pe_feeder: loads FC weights, pulses commit, streams ifmap then zero-flushes; FC_FEEDER_WEIGHT_REUSE_EN adds reuse_w_i
module fc_pe_feeder
    import fc_pkg::*;
#(
    parameter int FC_SIZE = FC_SIZE_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int LEN_W = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start_i,
    input  logic [LEN_W-1:0]                in_len_i,
`ifdef FC_FEEDER_WEIGHT_REUSE_EN
    input  logic                            reuse_w_i,
`endif
    input  logic                            w_valid_i,
    input  logic [DATA_W-1:0]               w_data_i,
    output logic                            w_ready_o,
    input  logic                            x_valid_i,
    input  logic [DATA_W-1:0]               x_data_i,
    output logic                            x_ready_o,
    output logic [FC_SIZE-1:0][DATA_W-1:0]  weight_o,
    output logic                            pe_load_o,
    output logic [DATA_W-1:0]               ifmap_o,
    output logic                            ifmap_valid_o,
    output logic                            busy_o,
    output logic                            done_o
);
    localparam int WIDX_W = (FC_SIZE > 1) ? $clog2(FC_SIZE) : 1;
    localparam int DRN_W = $clog2(FC_SIZE + 1);

    fc_feeder_state_t state, state_nx;
    logic [LEN_W-1:0] len, xidx;
    logic [WIDX_W-1:0] widx;
    logic [DRN_W-1:0] dcnt;
    logic w_hs, x_hs, start_ok, reuse;

    assign w_hs = w_valid_i & w_ready_o;
    assign x_hs = x_valid_i & x_ready_o;
    assign start_ok = start_i && (in_len_i != '0);
`ifdef FC_FEEDER_WEIGHT_REUSE_EN
    assign reuse = reuse_w_i;
`else
    assign reuse = 1'b0;
`endif

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = reuse ? STREAM : LOAD_W;
            LOAD_W:  if (w_hs && widx == WIDX_W'(FC_SIZE - 1)) state_nx = COMMIT;
            COMMIT:  state_nx = STREAM;
            STREAM:  if (x_hs && xidx == len - LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   if (dcnt == DRN_W'(FC_SIZE - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_ready_o = state == LOAD_W;
        x_ready_o = state == STREAM;
        pe_load_o = state == COMMIT;
        busy_o = state != IDLE;
        done_o = state == DONE;
    end

    // counters self-clear whenever their state is left, so a new job always starts from zero
    always_ff @(posedge clk)
        if (rst) begin
            len <= '0;
            xidx <= '0;
            widx <= '0;
            dcnt <= '0;
            ifmap_o <= '0;
            ifmap_valid_o <= 1'b0;
        end else begin
            if (state == IDLE && start_ok) len <= in_len_i;
            xidx <= (state == STREAM && state_nx == STREAM) ? xidx + LEN_W'(x_hs) : '0;
            widx <= (state_nx == LOAD_W) ? widx + WIDX_W'(w_hs) : '0;
            dcnt <= (state == DRAIN) ? dcnt + DRN_W'(1) : '0;
            ifmap_o <= x_hs ? x_data_i : '0;
            ifmap_valid_o <= x_hs;
        end

    fc_weight_shadow #(.FC_SIZE(FC_SIZE), .DATA_W(DATA_W), .IDX_W(WIDX_W)) u_shadow (
        .clk(clk),
        .rst(rst),
        .we(w_hs),
        .idx(widx),
        .wdata(w_data_i),
        .bank(weight_o)
    );
endmodule

// File: tb/tb_fc_pe_feeder.sv
// tb_fc_pe_feeder: randomized directed jobs checked against a job-level reference model
module tb_fc_pe_feeder;
    localparam int FC = 8;
    localparam int DW = 8;
    localparam int LW = 8;

    logic clk = 0;
    logic rst = 1;
    logic start_i = 0;
    logic [LW-1:0] in_len_i = '0;
    logic w_valid_i = 0, x_valid_i = 0;
    logic [DW-1:0] w_data_i = '0, x_data_i = '0;
    logic w_ready_o, x_ready_o, pe_load_o, ifmap_valid_o, busy_o, done_o;
    logic [FC-1:0][DW-1:0] weight_o;
    logic [DW-1:0] ifmap_o;
`ifdef FC_FEEDER_WEIGHT_REUSE_EN
    logic reuse_w = 0;
`endif

    fc_pe_feeder #(.FC_SIZE(FC), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk(clk),
        .rst(rst),
        .start_i(start_i),
        .in_len_i(in_len_i),
`ifdef FC_FEEDER_WEIGHT_REUSE_EN
        .reuse_w_i(reuse_w),
`endif
        .w_valid_i(w_valid_i),
        .w_data_i(w_data_i),
        .w_ready_o(w_ready_o),
        .x_valid_i(x_valid_i),
        .x_data_i(x_data_i),
        .x_ready_o(x_ready_o),
        .weight_o(weight_o),
        .pe_load_o(pe_load_o),
        .ifmap_o(ifmap_o),
        .ifmap_valid_o(ifmap_valid_o),
        .busy_o(busy_o),
        .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    logic [DW-1:0] wts[FC];
    logic [DW-1:0] xs[256];

    logic [DW-1:0] got_x[$];
    int hs_cyc[$], got_cyc[$];
    int cyc = 0, bubble_err = 0, load_cnt = 0, done_cnt = 0, done_c = 0, last_v = 0, wr_seen = 0;
    logic [63:0] load_w = '0;

    // observation only: what crossed the interfaces and when
    always @(negedge clk) begin
        cyc++;
        if (x_valid_i && x_ready_o) hs_cyc.push_back(cyc);
        if (ifmap_valid_o) begin
            got_x.push_back(ifmap_o);
            got_cyc.push_back(cyc);
            last_v = cyc;
        end else if (ifmap_o !== '0) bubble_err++;
        if (pe_load_o) begin
            load_cnt++;
            load_w = weight_o;
        end
        if (done_o) begin
            done_cnt++;
            done_c = cyc;
        end
        if (w_ready_o) wr_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] bank_of();
        logic [63:0] b;
        for (int i = 0; i < FC; i++) b[i*DW +: DW] = wts[i];
        return b;
    endfunction

    task automatic clear_mon();
        got_x.delete();
        hs_cyc.delete();
        got_cyc.delete();
        bubble_err = 0;
        load_cnt = 0;
        done_cnt = 0;
        wr_seen = 0;
        load_w = '0;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_w_ready"}, w_ready_o, 0);
        chk({tag, "_x_ready"}, x_ready_o, 0);
        chk({tag, "_pe_load"}, pe_load_o, 0);
        chk({tag, "_ifmap"}, ifmap_o, 0);
        chk({tag, "_ifmap_valid"}, ifmap_valid_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_weight"}, weight_o, 0);
    endtask

    task automatic do_start(input int len);
        start_i = 1;
        in_len_i = len[LW-1:0];
        @(posedge clk); #1;
        start_i = 0;
    endtask

    task automatic send_w(input int mode);
        int i = 0, g = 0;
        bit hs;
        while (i < FC && g < 2000) begin
            w_valid_i = (mode == 0) || (mode == 1 && g % 2 == 0) || (mode == 3 && $urandom_range(0, 1) == 1);
            w_data_i = wts[i];
            @(negedge clk); hs = w_valid_i && w_ready_o;
            @(posedge clk); #1; g++;
            if (hs) i++;
        end
        w_valid_i = 0;
        w_data_i = '0;
        chk("w_send_complete", i, FC);
    endtask

    task automatic send_x(input int n, input int mode);
        int i = 0, g = 0;
        bit hs;
        while (i < n && g < 5000) begin
            x_valid_i = (mode == 0) || (mode == 2 && g % 3 == 0) || (mode == 3 && $urandom_range(0, 1) == 1);
            x_data_i = xs[i];
            @(negedge clk); hs = x_valid_i && x_ready_o;
            @(posedge clk); #1; g++;
            if (hs) i++;
        end
        x_valid_i = 0;
        x_data_i = '0;
        chk("x_send_complete", i, n);
    endtask

    task automatic wait_done();
        int g = 0;
        @(negedge clk);
        while (!done_o && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done_o, 1);
        chk("busy_at_done", busy_o, 1);
        @(negedge clk);
        chk("done_one_cycle", done_o, 0);
        chk("busy_after_done", busy_o, 0);
        @(posedge clk); #1;
    endtask

    // reference: every sent byte appears once, in order, one cycle after its handshake,
    // the last one FC_SIZE cycles before done, bubbles read as zero
    task automatic check_job(input int len, input int exp_load);
        int lat_err = 0;
        chk("x_count", got_x.size(), len);
        for (int i = 0; i < len && i < got_x.size(); i++) chk("x_data", got_x[i], xs[i]);
        for (int i = 0; i < got_cyc.size() && i < hs_cyc.size(); i++) if (got_cyc[i] != hs_cyc[i] + 1) lat_err++;
        chk("x_latency", lat_err, 0);
        chk("bubble_zero", bubble_err, 0);
        chk("pe_load_count", load_cnt, exp_load);
        chk("done_count", done_cnt, 1);
        chk("drain_len", done_c - last_v, FC);
        chk("weight_hold", weight_o, bank_of());
    endtask

    task automatic run_job(input int len, input int wmode, input int xmode);
        clear_mon();
        do_start(len);
        chk("w_ready_after_start", w_ready_o, 1);
        send_w(wmode);
        send_x(len, xmode);
        wait_done();
        check_job(len, 1);
        chk("commit_bank", load_w, bank_of());
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < FC; i++) wts[i] = DW'($urandom);
        for (int i = 0; i < n; i++) xs[i] = DW'($urandom);
    endtask

    task automatic fill_basic();
        for (int i = 0; i < FC; i++) wts[i] = DW'(i + 1);
        for (int i = 0; i < 4; i++) xs[i] = DW'(8'h10 + i);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_idle_zero("reset");

        fill_basic();
        run_job(4, 0, 0);

        fill_random(6);
        run_job(6, 1, 2);

        clear_mon();
        start_i = 1;
        in_len_i = '0;
        @(posedge clk); #1;
        start_i = 0;
        chk("len0_busy", busy_o, 0);
        chk("len0_w_ready", w_ready_o, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0_no_load", load_cnt, 0);
        chk("len0_no_done", done_cnt, 0);

        fill_random(5);
        clear_mon();
        do_start(5);
        send_w(3);
        start_i = 1;
        in_len_i = 8'd9;
        send_x(5, 3);
        start_i = 0;
        wait_done();
        check_job(5, 1);
        chk("commit_bank_ign", load_w, bank_of());

        fill_random(5);
        clear_mon();
        do_start(5);
        send_w(0);
        send_x(2, 0);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_idle_zero("midrst");
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_done", done_cnt, 0);

        fill_basic();
        run_job(4, 0, 0);

        fill_random(255);
        run_job(255, 3, 0);

`ifdef FC_FEEDER_WEIGHT_REUSE_EN
        fill_basic();
        run_job(4, 0, 0);
        for (int i = 0; i < 3; i++) xs[i] = DW'($urandom);
        clear_mon();
        reuse_w = 1;
        do_start(3);
        reuse_w = 0;
        chk("reuse_x_ready_next", x_ready_o, 1);
        send_x(3, 3);
        wait_done();
        check_job(3, 0);
        chk("reuse_no_w_ready", wr_seen, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
